pd30_decoder: RTL and testbench

PD30_DECODER -- requirements
Module: pd30_decoder

---
 rtl/pd30_decoder.sv | 122 ++++++++++++
 tb/tb_pd30_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pd30_decoder.sv
// Priority-code decoder: a 2-entry FIFO of {in_any, in_code} feeds a two-state
// FSM that presents each decoded one-hot word on out for HOLD_CYCLES cycles.
module pd30_decoder #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_code,
    input  logic       in_any,
    output logic [3:0] out,
    output logic       out_valid,
    output logic       busy,
    output logic [7:0] count
);

    typedef enum logic {IDLE, DRIVE} state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] fifo_mem [0:1];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occupancy;
    logic [3:0] hold_cnt;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic       clear;
    logic [2:0] head;

    assign empty    = (occupancy == 2'd0);
    assign full     = (occupancy == 2'd2);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign head     = fifo_mem[rd_ptr];
    assign busy     = ~empty | (state == DRIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = DRIVE;
            DRIVE:   if (hold_cnt == 4'd0 && empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A pop only ever looks at registered occupancy, so a word pushed this edge
    // cannot be popped until the next one.
    always_comb begin
        pop   = 1'b0;
        clear = 1'b0;
        case (state)
            IDLE: pop = ~empty;
            DRIVE: begin
                if (hold_cnt == 4'd0) begin
                    pop   = ~empty;
                    clear = empty;
                end
            end
            default: clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= 3'd0;
            fifo_mem[1] <= 3'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occupancy   <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {in_any, in_code};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= 4'b0000;
            out_valid <= 1'b0;
            hold_cnt  <= 4'd0;
            count     <= 8'd0;
        end else if (pop) begin
            out       <= head[2] ? (4'b0001 << head[1:0]) : 4'b0000;
            out_valid <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
            if (head[2] && count != 8'd255) begin
                count <= count + 8'd1;
            end
        end else if (clear) begin
            out       <= 4'b0000;
            out_valid <= 1'b0;
            hold_cnt  <= 4'd0;
        end else if (state == DRIVE && hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_pd30_decoder.sv
// Directed bench for pd30_decoder: a per-cycle vector table for HOLD_CYCLES=3,
// then reset-mid-hold, count saturation and a HOLD_CYCLES=1 scoreboard stream.
module tb_pd30_decoder;

    typedef struct {
        logic       v;
        logic       a;
        logic [1:0] c;
        logic       rdy;
        logic [3:0] o;
        logic       ov;
        logic       bsy;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_any = 1'b0;
    logic [1:0] in_code = 2'd0;
    logic       in_ready;
    logic [3:0] out;
    logic       out_valid;
    logic       busy;
    logic [7:0] count;

    logic       v1 = 1'b0;
    logic       a1 = 1'b0;
    logic [1:0] c1 = 2'd0;
    logic       r1;
    logic [3:0] o1;
    logic       ov1;
    logic       b1;
    logic [7:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t       vecs [22];
    logic [2:0] sb [$];

    always #5 clk = ~clk;

    pd30_decoder #(.HOLD_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_any(in_any), .out(out), .out_valid(out_valid),
        .busy(busy), .count(count)
    );

    pd30_decoder #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .in_code(c1), .in_any(a1), .out(o1), .out_valid(ov1),
        .busy(b1), .count(cnt1)
    );

    function automatic vec_t mk(logic v, logic a, logic [1:0] c, logic rdy,
                                logic [3:0] o, logic ov, logic bsy, logic [7:0] cnt);
        vec_t r;
        r.v = v; r.a = a; r.c = c; r.rdy = rdy;
        r.o = o; r.ov = ov; r.bsy = bsy; r.cnt = cnt;
        return r;
    endfunction

    function automatic logic [3:0] decode(logic [2:0] w);
        return w[2] ? (4'b0001 << w[1:0]) : 4'b0000;
    endfunction

    task automatic check_value(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_vector(int idx);
        string tag;
        in_valid = vecs[idx].v;
        in_any   = vecs[idx].a;
        in_code  = vecs[idx].c;
        @(posedge clk);
        #1;
        tag = $sformatf("vec%0d", idx);
        check_value({tag, "_out"},   {28'd0, out},       {28'd0, vecs[idx].o});
        check_value({tag, "_ov"},    {31'd0, out_valid}, {31'd0, vecs[idx].ov});
        check_value({tag, "_ready"}, {31'd0, in_ready},  {31'd0, vecs[idx].rdy});
        check_value({tag, "_busy"},  {31'd0, busy},      {31'd0, vecs[idx].bsy});
        check_value({tag, "_count"}, {24'd0, count},     {24'd0, vecs[idx].cnt});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int cyc;
        int any_pushed;
        logic onehot_ok;

        vecs[0]  = mk(1, 1, 2'd2, 1, 4'b0000, 0, 1, 8'd0);
        vecs[1]  = mk(0, 0, 2'd0, 1, 4'b0100, 1, 1, 8'd1);
        vecs[2]  = mk(0, 0, 2'd0, 1, 4'b0100, 1, 1, 8'd1);
        vecs[3]  = mk(0, 0, 2'd0, 1, 4'b0100, 1, 1, 8'd1);
        vecs[4]  = mk(0, 0, 2'd0, 1, 4'b0000, 0, 0, 8'd1);
        vecs[5]  = mk(0, 0, 2'd0, 1, 4'b0000, 0, 0, 8'd1);
        vecs[6]  = mk(1, 1, 2'd3, 1, 4'b0000, 0, 1, 8'd1);
        vecs[7]  = mk(1, 1, 2'd1, 1, 4'b1000, 1, 1, 8'd2);
        vecs[8]  = mk(1, 1, 2'd0, 0, 4'b1000, 1, 1, 8'd2);
        vecs[9]  = mk(1, 1, 2'd2, 0, 4'b1000, 1, 1, 8'd2);
        vecs[10] = mk(1, 1, 2'd2, 1, 4'b0010, 1, 1, 8'd3);
        vecs[11] = mk(0, 0, 2'd0, 1, 4'b0010, 1, 1, 8'd3);
        vecs[12] = mk(0, 0, 2'd0, 1, 4'b0010, 1, 1, 8'd3);
        vecs[13] = mk(0, 0, 2'd0, 1, 4'b0001, 1, 1, 8'd4);
        vecs[14] = mk(0, 0, 2'd0, 1, 4'b0001, 1, 1, 8'd4);
        vecs[15] = mk(0, 0, 2'd0, 1, 4'b0001, 1, 1, 8'd4);
        vecs[16] = mk(0, 0, 2'd0, 1, 4'b0000, 0, 0, 8'd4);
        vecs[17] = mk(1, 0, 2'd3, 1, 4'b0000, 0, 1, 8'd4);
        vecs[18] = mk(0, 0, 2'd0, 1, 4'b0000, 1, 1, 8'd4);
        vecs[19] = mk(0, 0, 2'd0, 1, 4'b0000, 1, 1, 8'd4);
        vecs[20] = mk(0, 0, 2'd0, 1, 4'b0000, 1, 1, 8'd4);
        vecs[21] = mk(0, 0, 2'd0, 1, 4'b0000, 0, 0, 8'd4);

        // Reset values are checked while reset is still held.
        #3;
        check_value("rst_out",   {28'd0, out},       32'd0);
        check_value("rst_ov",    {31'd0, out_valid}, 32'd0);
        check_value("rst_busy",  {31'd0, busy},      32'd0);
        check_value("rst_ready", {31'd0, in_ready},  32'd1);
        check_value("rst_count", {24'd0, count},     32'd0);
        #9;
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            apply_vector(i);
        end

        // Three back-to-back pushes leave the FSM in the second cycle of a hold
        // with two words queued; reset there must discard everything at once.
        in_valid = 1'b1; in_any = 1'b1; in_code = 2'd3;
        step();
        in_code = 2'd1;
        step();
        in_code = 2'd0;
        step();
        in_valid = 1'b0;
        check_value("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_value("mid_rst_out",   {28'd0, out},       32'd0);
        check_value("mid_rst_ov",    {31'd0, out_valid}, 32'd0);
        check_value("mid_rst_busy",  {31'd0, busy},      32'd0);
        check_value("mid_rst_ready", {31'd0, in_ready},  32'd1);
        check_value("mid_rst_count", {24'd0, count},     32'd0);
        step();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_value("post_rst_ov",   {31'd0, out_valid}, 32'd0);
            check_value("post_rst_busy", {31'd0, busy},      32'd0);
        end

        // 300 words with in_any=1: count must stop at 255.
        pushed    = 0;
        cyc       = 0;
        onehot_ok = 1'b1;
        in_valid  = 1'b1;
        in_any    = 1'b1;
        in_code   = 2'd0;
        while (pushed < 300 && cyc < 2000) begin
            logic acc;
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) pushed++;
            if (!$onehot0(out)) onehot_ok = 1'b0;
            in_code  = 2'($urandom_range(0, 3));
            in_valid = (pushed < 300);
        end
        in_valid = 1'b0;
        check_value("sat_pushed", pushed, 300);
        while (busy && cyc < 3000) begin
            step();
            cyc++;
            if (!$onehot0(out)) onehot_ok = 1'b0;
        end
        check_value("sat_drained", {31'd0, busy},  32'd0);
        check_value("sat_count",   {24'd0, count}, 32'd255);
        check_value("sat_onehot",  {31'd0, onehot_ok}, 32'd1);

        // HOLD_CYCLES=1: a continuous stream yields one word per cycle, then a
        // gappy stream is checked against the scoreboard for drops/duplicates.
        any_pushed = 0;
        v1 = 1'b1;
        a1 = 1'($urandom_range(0, 1));
        c1 = 2'($urandom_range(0, 3));
        for (int k = 1; k <= 60; k++) begin
            logic       p;
            logic [2:0] w;
            p = v1 && r1;
            w = {a1, c1};
            step();
            if (ov1) begin
                if (sb.size() == 0) begin
                    check_value("h1_extra_word", {31'd0, ov1}, 32'd0);
                end else begin
                    check_value("h1_word", {28'd0, o1}, {28'd0, decode(sb.pop_front())});
                end
            end
            if (k >= 2 && k <= 20) begin
                check_value("h1_steady_ov", {31'd0, ov1}, 32'd1);
            end
            if (p) begin
                sb.push_back(w);
                if (w[2]) any_pushed++;
            end
            v1 = (k < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            a1 = 1'($urandom_range(0, 1));
            c1 = 2'($urandom_range(0, 3));
        end
        v1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ov1) begin
                if (sb.size() == 0) begin
                    check_value("h1_extra_word", {31'd0, ov1}, 32'd0);
                end else begin
                    check_value("h1_word", {28'd0, o1}, {28'd0, decode(sb.pop_front())});
                end
            end
        end
        check_value("h1_left_in_sb", sb.size(), 0);
        check_value("h1_final_ov",   {31'd0, ov1},  32'd0);
        check_value("h1_count",      {24'd0, cnt1}, any_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
